hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the decoder/ID stage and drives PC, IF/ID, ID/EX and EX/MEM write-enables, bubbles and flushes.
- Handles three hazard classes:
  - load-use stall;
  - multi-cycle MUL occupancy of EX (counter-driven FSM);
  - control-flow flush for J/BEQ.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LAT, 4: total cycles a MUL occupies EX. Legal range 1..16.
- CNT_W, 4: width of the MUL down-counter. Must satisfy 2^CNT_W >= MUL_LAT.
- PERF_W, 16: width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- id_rs_i  in  5  rs field of the instruction in ID.
- id_rt_i  in  5  rt field of the instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt as a source (R-type, BEQ, SW).
- ex_mem_read_i  in  1  ID/EX holds a valid LW (MEM_cs=1, MEM_we=0).
- ex_rt_i  in  5  destination rt of the instruction in ID/EX.
- ex_mul_i  in  1  ID/EX holds a valid MUL.
- jump_i  in  1  ID decodes J.
- branch_taken_i  in  1  ID BEQ resolved as taken.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register write enable.
- ifid_flush_o  out  1  zero IF/ID on the next edge.
- idex_write_o  out  1  ID/EX register write enable.
- idex_bubble_o  out  1  load all-zero control into ID/EX.
- exmem_bubble_o  out  1  load all-zero control into EX/MEM.
- mul_busy_o  out  1  FSM is in state MUL.
- stall_cnt_o  out  PERF_W  saturating count of stall cycles.

Behaviour:
- FSM states: RUN=0, MUL=1. Registered signals: state, cnt[CNT_W], stall_cnt.
- On rst_i=1 (asynchronous): state=RUN, cnt=0, stall_cnt=0.
- With all inputs at 0 after reset, outputs are: pc_write_o=1, ifid_write_o=1, idex_write_o=1; all other outputs 0.
- Reset asserted mid-MUL returns the FSM to RUN immediately and releases the stall in the same cycle.
- mul_stall (combinational):
  - (state==RUN && ex_mul_i && MUL_LAT>1), or
  - (state==MUL && cnt!=0).
- FSM transitions:
  - RUN with ex_mul_i=1 and MUL_LAT>1: go to MUL, load cnt=MUL_LAT-2.
  - MUL with cnt!=0: decrement cnt, stay in MUL.
  - MUL with cnt==0: no stall this cycle; the MUL advances; go to RUN.
- MUL timing:
  - EX occupancy is exactly MUL_LAT cycles; stall cycles total MUL_LAT-1.
  - Back-to-back MULs re-trigger from RUN with no gap cycle.
  - MUL_LAT=1: never leaves RUN and never stalls.
- load_use (combinational) = ex_mem_read_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)).
- Output priority 1, mul_stall: pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_bubble_o=1, ifid_flush_o=0, idex_bubble_o=0.
- Output priority 2, load_use (and no mul_stall):
  - pc_write_o=0, ifid_write_o=0, idex_write_o=1, idex_bubble_o=1, ifid_flush_o=0.
  - Exactly one stall cycle; on the next cycle the LW is in MEM, so ex_mem_read_i drops.
- Output priority 3, (jump_i || branch_taken_i) with neither stall: ifid_flush_o=1, all write enables 1.
- Output default: all write enables 1; ifid_flush_o, idex_bubble_o and exmem_bubble_o are 0.
- A branch in ID during a stall is held, not flushed. It is re-evaluated once the stall clears.
- ex_mul_i and ex_mem_read_i are never both 1 by decode. If both are 1, MUL priority applies.
- stall_cnt increments on every cycle where mul_stall||load_use. It saturates at all-ones and never wraps.
- mul_busy_o = (state==MUL).
- All outputs except stall_cnt_o are combinational from state/cnt and inputs; there is no extra output latency.

Test Plan:
- Reset: rst_i pulsed mid-cycle, inputs 0 -> pc_write_o=1, ifid_write_o=1, idex_write_o=1, bubble/flush outputs 0, stall_cnt_o=0, mul_busy_o=0.
- Load-use: ex_mem_read_i=1, ex_rt_i=5, id_rs_i=5 -> one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o=1 afterwards. Repeat with ex_rt_i=0 -> no stall.
- rt dependency: ex_rt_i=7, id_rt_i=7, id_uses_rt_i=0 -> no stall. Same with id_uses_rt_i=1 -> stall.
- MUL, MUL_LAT=4: ex_mul_i=1 for one cycle in RUN -> exmem_bubble_o=1 and pc_write_o=0 for 3 cycles, mul_busy_o=1 for 3 cycles, then RUN; stall_cnt_o=3. Back-to-back MULs -> 6 stall cycles, no gap.
- Flush vs stall: branch_taken_i=1 together with load_use=1 -> ifid_flush_o=0 that cycle. Next cycle, load_use=0 and branch still taken -> ifid_flush_o=1. jump_i=1 alone -> ifid_flush_o=1 with pc_write_o=1.
- Reset mid-MUL: rst_i asserted at cnt=1 -> mul_busy_o=0 and pc_write_o=1 immediately. Also force stall_cnt to all-ones (PERF_W=4, 20 stall cycles) -> stall_cnt_o holds 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stall, multi-cycle
// MUL occupancy of EX, J/BEQ flush, and a saturating stall-cycle counter.
//
// state | meaning
// RUN   | normal issue; a MUL entering EX starts the occupancy countdown
// MUL   | MUL still occupying EX; stall while cnt != 0, release at cnt == 0
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 4,
    parameter int PERF_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_mem_read_i,
    input  logic [4:0]        ex_rt_i,
    input  logic              ex_mul_i,
    input  logic              jump_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_write_o,
    output logic              idex_bubble_o,
    output logic              exmem_bubble_o,
    output logic              mul_busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    // MUL_LAT == 1 keeps the FSM in RUN, so the load value is never used there.
    localparam bit              MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PERF_W-1:0] stall_cnt;
    logic             mul_stall;
    logic             load_use;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((mul_stall || load_use) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        mul_stall = ((state == RUN) && ex_mul_i && MUL_MULTI) ||
                    ((state == MUL) && (cnt != '0));
        load_use  = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (ex_mul_i && MUL_MULTI) begin
                    state_nxt = MUL;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MUL: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A taken branch seen during a stall is held in ID and re-evaluated later.
    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        idex_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        if (mul_stall) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_bubble_o = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (jump_i || branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    assign mul_busy_o  = (state == MUL);
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default instance plus a 4-bit perf
// counter instance and a MUL_LAT=1 instance sharing the same stimulus.
module tb_hazard_stall_ctrl;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy}
    localparam logic [6:0] OUT_RUN  = 7'b1101000;
    localparam logic [6:0] OUT_LU   = 7'b0001100;
    localparam logic [6:0] OUT_MULR = 7'b0000010;
    localparam logic [6:0] OUT_MULB = 7'b0000011;
    localparam logic [6:0] OUT_MUL0 = 7'b1101001;
    localparam logic [6:0] OUT_FL   = 7'b1111000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
    logic       id_uses_rt_i = 1'b0, ex_mem_read_i = 1'b0, ex_mul_i = 1'b0;
    logic       jump_i = 1'b0, branch_taken_i = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy;
    logic [15:0] stall_cnt;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_bubble, s_exmem_bubble, s_mul_busy;
    logic [3:0]  s_stall_cnt;
    logic        l_pc_write, l_ifid_write, l_ifid_flush, l_idex_write, l_idex_bubble, l_exmem_bubble, l_mul_busy;
    logic [15:0] l_stall_cnt;
    logic [6:0]  obs, obs_l1;

    int n_tests = 0;
    int n_fail  = 0;

    assign obs    = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy};
    assign obs_l1 = {l_pc_write, l_ifid_write, l_ifid_flush, l_idex_write, l_idex_bubble, l_exmem_bubble, l_mul_busy};

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
        .ex_mul_i(ex_mul_i), .jump_i(jump_i), .branch_taken_i(branch_taken_i),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_write_o(idex_write), .idex_bubble_o(idex_bubble), .exmem_bubble_o(exmem_bubble),
        .mul_busy_o(mul_busy), .stall_cnt_o(stall_cnt)
    );

    hazard_stall_ctrl #(.PERF_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
        .ex_mul_i(ex_mul_i), .jump_i(jump_i), .branch_taken_i(branch_taken_i),
        .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
        .idex_write_o(s_idex_write), .idex_bubble_o(s_idex_bubble), .exmem_bubble_o(s_exmem_bubble),
        .mul_busy_o(s_mul_busy), .stall_cnt_o(s_stall_cnt)
    );

    hazard_stall_ctrl #(.MUL_LAT(1)) dut_l1 (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
        .ex_mul_i(ex_mul_i), .jump_i(jump_i), .branch_taken_i(branch_taken_i),
        .pc_write_o(l_pc_write), .ifid_write_o(l_ifid_write), .ifid_flush_o(l_ifid_flush),
        .idex_write_o(l_idex_write), .idex_bubble_o(l_idex_bubble), .exmem_bubble_o(l_exmem_bubble),
        .mul_busy_o(l_mul_busy), .stall_cnt_o(l_stall_cnt)
    );

    task automatic clear_inputs();
        id_rs_i = '0; id_rt_i = '0; ex_rt_i = '0;
        id_uses_rt_i = 1'b0; ex_mem_read_i = 1'b0; ex_mul_i = 1'b0;
        jump_i = 1'b0; branch_taken_i = 1'b0;
    endtask

    // Reset pulse asserted mid-cycle, held across one rising edge.
    task automatic do_reset();
        @(negedge clk_i);
        clear_inputs();
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        ex_mem_read_i = 1'b1; ex_rt_i = 5'd9; id_rs_i = 5'd9;
        @(negedge clk_i);
        clear_inputs();
        #3 rst_i = 1'b1;
        #1;
        n_tests++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, OUT_RUN);
        end
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk_i);
        ex_mem_read_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5;
        #1;
        n_tests++;
        if (obs !== OUT_LU) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected %b", obs, OUT_LU);
        end
        @(negedge clk_i);
        clear_inputs();
        #1;
        n_tests++;
        if (obs !== OUT_RUN || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_release: got %b cnt %0d expected %b cnt 1", obs, stall_cnt, OUT_RUN);
        end
        @(negedge clk_i);
        ex_mem_read_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
        #1;
        n_tests++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL load_use_r0: got %b expected %b", obs, OUT_RUN);
        end
        @(negedge clk_i);
        clear_inputs();
        n_tests++;
        if (stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_r0_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_rt_dep();
        do_reset();
        @(negedge clk_i);
        ex_mem_read_i = 1'b1; ex_rt_i = 5'd7; id_rt_i = 5'd7; id_rs_i = 5'd3; id_uses_rt_i = 1'b0;
        #1;
        n_tests++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL rt_dep_unused: got %b expected %b", obs, OUT_RUN);
        end
        @(negedge clk_i);
        id_uses_rt_i = 1'b1;
        #1;
        n_tests++;
        if (obs !== OUT_LU) begin
            n_fail++;
            $display("FAIL rt_dep_used: got %b expected %b", obs, OUT_LU);
        end
        @(negedge clk_i);
        clear_inputs();
        n_tests++;
        if (stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rt_dep_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_mul();
        logic [6:0] exp_seq [4];
        exp_seq = '{OUT_MULR, OUT_MULB, OUT_MULB, OUT_MUL0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            ex_mul_i = 1'b1;
            #1;
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL mul_cycle%0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            n_tests++;
            if (obs_l1 !== OUT_RUN) begin
                n_fail++;
                $display("FAIL mul_lat1_cycle%0d: got %b expected %b", i, obs_l1, OUT_RUN);
            end
        end
        @(negedge clk_i);
        clear_inputs();
        #1;
        n_tests++;
        if (obs !== OUT_RUN || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL mul_done: got %b cnt %0d expected %b cnt 3", obs, stall_cnt, OUT_RUN);
        end
        n_tests++;
        if (l_stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mul_lat1_cnt: got %0d expected 0", l_stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seq [4];
        exp_seq = '{OUT_MULR, OUT_MULB, OUT_MULB, OUT_MUL0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            ex_mul_i = 1'b1;
            #1;
            n_tests++;
            if (obs !== exp_seq[i % 4]) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs, exp_seq[i % 4]);
            end
        end
        @(negedge clk_i);
        clear_inputs();
        #1;
        n_tests++;
        if (obs !== OUT_RUN || stall_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL b2b_done: got %b cnt %0d expected %b cnt 6", obs, stall_cnt, OUT_RUN);
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk_i);
        ex_mem_read_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; branch_taken_i = 1'b1;
        #1;
        n_tests++;
        if (obs !== OUT_LU) begin
            n_fail++;
            $display("FAIL flush_held_by_stall: got %b expected %b", obs, OUT_LU);
        end
        @(negedge clk_i);
        ex_mem_read_i = 1'b0;
        #1;
        n_tests++;
        if (obs !== OUT_FL) begin
            n_fail++;
            $display("FAIL flush_branch: got %b expected %b", obs, OUT_FL);
        end
        @(negedge clk_i);
        clear_inputs();
        jump_i = 1'b1;
        #1;
        n_tests++;
        if (obs !== OUT_FL) begin
            n_fail++;
            $display("FAIL flush_jump: got %b expected %b", obs, OUT_FL);
        end
        @(negedge clk_i);
        clear_inputs();
        ex_mul_i = 1'b1; ex_mem_read_i = 1'b1; ex_rt_i = 5'd4; id_rs_i = 5'd4; branch_taken_i = 1'b1;
        #1;
        n_tests++;
        if (obs !== OUT_MULR) begin
            n_fail++;
            $display("FAIL mul_over_load_use: got %b expected %b", obs, OUT_MULR);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            ex_mul_i = 1'b1;
        end
        #1;
        n_tests++;
        if (obs !== OUT_MULB) begin
            n_fail++;
            $display("FAIL mid_mul_before: got %b expected %b", obs, OUT_MULB);
        end
        #1 rst_i = 1'b1;
        ex_mul_i = 1'b0;
        #1;
        n_tests++;
        if (obs !== OUT_RUN || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_mul_reset: got %b cnt %0d expected %b cnt 0", obs, stall_cnt, OUT_RUN);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_tests++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL mid_mul_after: got %b expected %b", obs, OUT_RUN);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            ex_mem_read_i = 1'b1; ex_rt_i = 5'd2; id_rs_i = 5'd2;
            if (i == 15) begin
                n_tests++;
                if (s_stall_cnt !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_reach: got %0d expected 15", s_stall_cnt);
                end
            end
        end
        @(negedge clk_i);
        clear_inputs();
        n_tests++;
        if (s_stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d expected 15", s_stall_cnt);
        end
        n_tests++;
        if (stall_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_wide_cnt: got %0d expected 20", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rt_dep();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
